pe_dot_ctrl: RTL and testbench

Sequencing controller that drives a single MAC processing element (`pe`) through one complete dot-product job. It takes a command carrying a bias and a vector length, and preloads the bias via `load_acc`. It then streams the operand pairs into the PE with `en`, waits out the PE accumulate latency, captures `acc_out` and returns it on a valid/ready result port. It sits between the array scheduler / operand memories and one PE, and is the initiator for the PE's `en`/`load_acc`/`a_in`/`b_in`/`acc_out` interface.

---
 rtl/pe_dot_ctrl.sv | 128 ++++++++++++
 tb/tb_pe_dot_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_ctrl.sv
// pe_dot_ctrl: sequences one MAC processing element through a single dot-product job.
//
// Flow: accept a command (bias, length), preload the PE accumulator with the bias,
// stream `length` operand pairs into the PE, wait out the PE accumulate latency,
// then capture the PE accumulator and offer it on the result port.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_len, cmd_bias payload
//   op_valid/op_ready             operand handshake; op_a, op_b payload
//   res_valid/res_ready           result handshake; res_data payload
//   busy                          high whenever a job is in progress
//   pe_en, pe_load_acc            PE control (registered)
//   pe_a, pe_b, pe_partial_sum    PE operands / preload value (registered)
//   pe_acc                        PE accumulator output
module pe_dot_ctrl #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ACC_W   = 32,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned ACC_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [ACC_W-1:0]  cmd_bias,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              busy,
   output logic              pe_en,
   output logic              pe_load_acc,
   output logic [DATA_W-1:0] pe_a,
   output logic [DATA_W-1:0] pe_b,
   output logic [ACC_W-1:0]  pe_partial_sum,
   input  logic [ACC_W-1:0]  pe_acc
);

   // DRAIN spans ACC_LAT+1 cycles: one to drop pe_en, ACC_LAT for the PE to settle.
   localparam int unsigned DRAIN_W = $clog2(ACC_LAT + 2);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ACC_LAT);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StMac,
      StDrain,
      StResp
   } state_e;

   state_e             state_q;
   logic [LEN_W-1:0]   remaining_q;
   logic [DRAIN_W-1:0] drain_q;

   // Handshake outputs are pure state decodes: no input-to-output combinational path.
   assign cmd_ready = (state_q == StIdle);
   assign op_ready  = (state_q == StMac);
   assign res_valid = (state_q == StResp);
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         remaining_q    <= '0;
         drain_q        <= '0;
         res_data       <= '0;
         pe_en          <= 1'b0;
         pe_load_acc    <= 1'b0;
         pe_a           <= '0;
         pe_b           <= '0;
         pe_partial_sum <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  remaining_q    <= cmd_len;
                  pe_partial_sum <= cmd_bias;
                  pe_load_acc    <= 1'b1;
                  state_q        <= StLoad;
               end
            end
            StLoad: begin
               pe_load_acc <= 1'b0;
               drain_q     <= '0;
               state_q     <= (remaining_q == '0) ? StDrain : StMac;
            end
            StMac: begin
               if (op_valid) begin
                  pe_a        <= op_a;
                  pe_b        <= op_b;
                  pe_en       <= 1'b1;
                  remaining_q <= remaining_q - LEN_W'(1);
                  // Leaving on the last pair means the counter never wraps.
                  if (remaining_q == LEN_W'(1)) begin
                     state_q <= StDrain;
                  end
               end else begin
                  // Stall: PE holds its accumulator, operands stay visible downstream.
                  pe_en <= 1'b0;
               end
            end
            StDrain: begin
               pe_en <= 1'b0;
               if (drain_q == DRAIN_LAST) begin
                  res_data <= pe_acc;
                  state_q  <= StResp;
               end else begin
                  drain_q <= drain_q + DRAIN_W'(1);
               end
            end
            StResp: begin
               if (res_ready) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_dot_ctrl.sv
// tb_pe_dot_ctrl: directed bench for pe_dot_ctrl with a behavioural PE attached.
// A transaction-level model predicts every output each cycle; directed jobs add
// hand-computed results, latencies and pulse counts.
module tb_pe_dot_ctrl;

   localparam int DATA_W  = 16;
   localparam int ACC_W   = 32;
   localparam int LEN_W   = 8;
   localparam int ACC_LAT = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic [ACC_W-1:0]  cmd_bias = '0;
   logic              op_valid = 1'b0;
   logic              op_ready;
   logic [DATA_W-1:0] op_a = '0;
   logic [DATA_W-1:0] op_b = '0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [ACC_W-1:0]  res_data;
   logic              busy;
   logic              pe_en;
   logic              pe_load_acc;
   logic [DATA_W-1:0] pe_a;
   logic [DATA_W-1:0] pe_b;
   logic [ACC_W-1:0]  pe_partial_sum;
   logic [ACC_W-1:0]  pe_acc;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cmd_edge = 0;
   int en_total = 0;
   int load_total = 0;
   int opr_total = 0;

   pe_dot_ctrl #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .LEN_W  (LEN_W),
      .ACC_LAT(ACC_LAT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_len       (cmd_len),
      .cmd_bias      (cmd_bias),
      .op_valid      (op_valid),
      .op_ready      (op_ready),
      .op_a          (op_a),
      .op_b          (op_b),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .busy          (busy),
      .pe_en         (pe_en),
      .pe_load_acc   (pe_load_acc),
      .pe_a          (pe_a),
      .pe_b          (pe_b),
      .pe_partial_sum(pe_partial_sum),
      .pe_acc        (pe_acc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural PE with a one-cycle accumulate latency.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pe_acc <= '0;
      else if (pe_load_acc) pe_acc <= pe_partial_sum;
      else if (pe_en) pe_acc <= pe_acc + (32'(pe_a) * 32'(pe_b));
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   bit          m_busy, m_res_valid, m_pe_en, m_pe_load, m_in_load;
   logic [31:0] m_res_data, m_ps, m_acc;
   logic [15:0] m_a, m_b;
   int          m_ops_left, m_cd;

   task automatic model_reset();
      m_busy = 0; m_res_valid = 0; m_pe_en = 0; m_pe_load = 0; m_in_load = 0;
      m_res_data = '0; m_ps = '0; m_acc = '0; m_a = '0; m_b = '0;
      m_ops_left = 0; m_cd = 0;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      bit e_op_ready, cmd_hs, op_hs, res_hs;
      if (!rst_n) model_reset();
      e_op_ready = m_busy && (m_ops_left > 0) && !m_in_load;
      chk("mon_busy", busy, m_busy);
      chk("mon_cmd_ready", cmd_ready, !m_busy);
      chk("mon_op_ready", op_ready, e_op_ready);
      chk("mon_res_valid", res_valid, m_res_valid);
      chk("mon_res_data", res_data, m_res_data);
      chk("mon_pe_en", pe_en, m_pe_en);
      chk("mon_pe_load_acc", pe_load_acc, m_pe_load);
      chk("mon_pe_a", pe_a, m_a);
      chk("mon_pe_b", pe_b, m_b);
      chk("mon_pe_partial_sum", pe_partial_sum, m_ps);
      if (pe_en) en_total++;
      if (pe_load_acc) load_total++;
      if (op_ready) opr_total++;
      if (rst_n) begin
         // Inputs are stable here until the next rising edge; predict that edge.
         cmd_hs = !m_busy && cmd_valid;
         op_hs  = e_op_ready && op_valid;
         res_hs = m_res_valid && res_ready;
         m_pe_load = cmd_hs;
         m_in_load = cmd_hs;
         m_pe_en   = op_hs;
         if (cmd_hs) begin
            m_ps = cmd_bias;
            m_busy = 1;
            m_acc = cmd_bias;
            m_ops_left = int'(cmd_len);
            // Zero length: result ACC_LAT+2 edges after the command edge.
            if (cmd_len == '0) m_cd = ACC_LAT + 3;
         end
         if (op_hs) begin
            m_a = op_a;
            m_b = op_b;
            m_acc = m_acc + (32'(op_a) * 32'(op_b));
            m_ops_left--;
            // Result ACC_LAT+1 edges after the final operand edge.
            if (m_ops_left == 0) m_cd = ACC_LAT + 2;
         end
         if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin
               m_res_valid = 1;
               m_res_data = m_acc;
            end
         end
         if (res_hs) begin
            m_res_valid = 0;
            m_busy = 0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_op_ready"}, op_ready, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_pe_en"}, pe_en, 0);
      chk({tag, "_pe_load_acc"}, pe_load_acc, 0);
      chk({tag, "_pe_a"}, pe_a, 0);
      chk({tag, "_pe_b"}, pe_b, 0);
      chk({tag, "_pe_partial_sum"}, pe_partial_sum, 0);
   endtask

   task automatic send_cmd(input logic [31:0] bias, input logic [7:0] len);
      int n = 0;
      cmd_bias = bias;
      cmd_len = len;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      cmd_edge = cyc;
      cmd_valid = 1'b0;
      chk("cmd_load_acc", pe_load_acc, 1);
      chk("cmd_partial_sum", pe_partial_sum, bias);
   endtask

   task automatic send_op(input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      op_a = a;
      op_b = b;
      op_valid = 1'b1;
      while (!op_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!op_ready) begin
         chk("op_timeout", 0, 1);
         op_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      chk("op_pe_en", pe_en, 1);
      chk("op_pe_a", pe_a, a);
      chk("op_pe_b", pe_b, b);
   endtask

   task automatic get_result(input int hold, output logic [31:0] res, output int lat);
      int n = 0;
      res = '0;
      lat = -1;
      while (!res_valid && n < 600) begin
         @(posedge clk); #1;
         n++;
      end
      if (!res_valid) begin
         chk("res_timeout", 0, 1);
         return;
      end
      lat = cyc - cmd_edge;
      res = res_data;
      repeat (hold) begin
         @(posedge clk); #1;
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_data", res_data, res);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_busy", busy, 1);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("after_res_valid", res_valid, 0);
      chk("after_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      logic [31:0] res;
      int lat, en0, ld0, opr0;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // Dot product with 5 cycles of result backpressure.
      en0 = en_total;
      send_cmd(32'd0, 8'd4);
      send_op(16'd1, 16'd5);
      send_op(16'd2, 16'd6);
      send_op(16'd3, 16'd7);
      send_op(16'd4, 16'd8);
      get_result(5, res, lat);
      chk("dot_res", res, 32'd70);
      chk("dot_lat", lat, 7);
      chk("dot_en_cycles", en_total - en0, 4);

      // Bias preload.
      ld0 = load_total;
      send_cmd(32'd1000, 8'd1);
      send_op(16'd5, 16'd5);
      get_result(0, res, lat);
      chk("pre_res", res, 32'd1025);
      chk("pre_load_cycles", load_total - ld0, 1);
      chk("pre_lat", lat, 4);

      // Operand stall: junk on the bus while op_valid is low.
      send_cmd(32'd0, 8'd2);
      send_op(16'd2, 16'd2);
      op_a = 16'd100;
      op_b = 16'd100;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_pe_en", pe_en, 0);
         chk("stall_pe_a", pe_a, 2);
         chk("stall_pe_b", pe_b, 2);
      end
      send_op(16'd2, 16'd2);
      get_result(0, res, lat);
      chk("stall_res", res, 32'd8);
      chk("stall_lat", lat, 8);

      // Zero length with an operand offered throughout.
      en0 = en_total;
      opr0 = opr_total;
      send_cmd(32'hDEADBEEF, 8'd0);
      op_a = 16'd9;
      op_b = 16'd9;
      op_valid = 1'b1;
      get_result(0, res, lat);
      op_valid = 1'b0;
      chk("zero_res", res, 32'hDEADBEEF);
      chk("zero_lat", lat, 3);
      chk("zero_op_ready_cycles", opr_total - opr0, 0);
      chk("zero_en_cycles", en_total - en0, 0);

      // Modular wrap.
      send_cmd(32'd0, 8'd2);
      send_op(16'hFFFF, 16'hFFFF);
      send_op(16'hFFFF, 16'hFFFF);
      get_result(0, res, lat);
      chk("wrap_res", res, 32'hFFFC0002);

      // Reset mid-MAC after 2 of 4 operands.
      send_cmd(32'd7, 8'd4);
      send_op(16'd1, 16'd1);
      send_op(16'd2, 16'd2);
      rst_n = 1'b0;
      #2;
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Fresh job after reset.
      send_cmd(32'd0, 8'd1);
      send_op(16'd42, 16'd1);
      get_result(0, res, lat);
      chk("fresh_res", res, 32'd42);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
      $fatal(1, "timeout");
   end

endmodule
